// File: rtl/pwm_multichannel_gen_pkg.sv
// Shared constants, direction type and prescaler mask helper for the multichannel PWM generator.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam int unsigned DEF_PERIOD = 100;
  localparam int unsigned DEF_CW     = 7;
  localparam int unsigned CONF_W     = 3;
  localparam int unsigned PRESC_W    = 7;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Low 'conf' bits set: tick fires when all of them are set in the prescaler count.
  function automatic logic [PRESC_W-1:0] presc_mask(input logic [CONF_W-1:0] conf);
    logic [PRESC_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < PRESC_W; i++) begin
      if (i < 32'(conf)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pwm_multichannel_gen_if.sv
// Control/status bundle of the multichannel PWM generator.
interface pwm_multichannel_gen_if #(
  parameter int unsigned N_CH = 4
) ();
  import pwm_pkg::*;

  logic              ena;
  logic [CONF_W-1:0] conf;
  logic              mode;
  logic [N_CH-1:0]   xu;
  logic [N_CH-1:0]   xd;
  logic [N_CH-1:0]   pwm;
  logic              sync;

  modport master (output ena, conf, mode, xu, xd, input pwm, sync);
  modport slave  (input ena, conf, mode, xu, xd, output pwm, sync);

endinterface

// File: rtl/pwm_multichannel_gen_duty_ctrl.sv
// Per-channel duty control: xu/xd edge detect, saturating shadow duty, load at period boundary.
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD = DEF_PERIOD,
  parameter int unsigned CW     = DEF_CW,
  parameter int unsigned STEP   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena_i,
  input  logic          load_i,
  input  logic          xu_i,
  input  logic          xd_i,
  output logic [CW-1:0] duty_o
);

  logic          xu_q, xd_q;
  logic [CW-1:0] shadow_q, shadow_d;
  logic [CW-1:0] duty_q, duty_d;
  logic          up, dn;
  logic [CW:0]   ext, sum;

  always_comb begin
    up       = ena_i & xu_i & ~xu_q;
    dn       = ena_i & xd_i & ~xd_q;
    ext      = {1'b0, shadow_q};
    sum      = ext + (CW+1)'(STEP);
    shadow_d = shadow_q;
    if (up && !dn) begin
      shadow_d = (sum > (CW+1)'(PERIOD)) ? CW'(PERIOD) : sum[CW-1:0];
    end else if (dn && !up) begin
      shadow_d = (ext >= (CW+1)'(STEP)) ? shadow_q - CW'(STEP) : '0;
    end
    duty_d = load_i ? shadow_q : duty_q;
  end

  // Edge registers track the inputs even while disabled, so re-enable never fires a stale edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      xu_q     <= 1'b0;
      xd_q     <= 1'b0;
      shadow_q <= '0;
      duty_q   <= '0;
    end else begin
      xu_q     <= xu_i;
      xd_q     <= xd_i;
      shadow_q <= shadow_d;
      duty_q   <= duty_d;
    end
  end

  assign duty_o = duty_q;

endmodule

// File: rtl/pwm_multichannel_gen.sv
// N-channel PWM generator: shared prescaler and period counter, edge/center aligned modes.
module pwm_multichannel_gen
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned PERIOD = DEF_PERIOD,
  parameter int unsigned CW     = DEF_CW,
  parameter int unsigned STEP   = 1
) (
  input logic                  clk,
  input logic                  rst,
  pwm_multichannel_gen_if.slave bus
);

  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [PRESC_W-1:0] presc_q, presc_d, mask;
  logic               tick, boundary;
  logic [CW-1:0]      cnt_q, cnt_d;
  dir_e               dir_q, dir_d;
  logic               mode_q, mode_d;
  logic [N_CH-1:0]    pwm_q, pwm_d;
  logic               sync_q;
  logic [CW-1:0]      duty [N_CH];

  always_comb begin
    mask     = presc_mask(bus.conf);
    tick     = ((presc_q & mask) == mask);
    presc_d  = bus.ena ? presc_q + PRESC_W'(1) : presc_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (bus.ena && tick) begin
      if (mode_q == MODE_EDGE) begin
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (dir_q == DIR_UP) begin
        if (cnt_q == LAST) dir_d = DIR_DOWN;
        else               cnt_d = cnt_q + CW'(1);
      end else begin
        // Both endpoints are held for one tick; the hold at zero is the period boundary.
        if (cnt_q == '0) begin
          dir_d    = DIR_UP;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    end
    mode_d = boundary ? bus.mode : mode_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      pwm_d[i] = bus.ena & (cnt_q < duty[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
      mode_q  <= MODE_EDGE;
      pwm_q   <= '0;
      sync_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      pwm_q   <= pwm_d;
      sync_q  <= boundary;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pwm_duty_ctrl #(
      .PERIOD(PERIOD),
      .CW    (CW),
      .STEP  (STEP)
    ) u_duty (
      .clk   (clk),
      .rst   (rst),
      .ena_i (bus.ena),
      .load_i(boundary),
      .xu_i  (bus.xu[g]),
      .xd_i  (bus.xd[g]),
      .duty_o(duty[g])
    );
  end

  assign bus.pwm  = pwm_q;
  assign bus.sync = sync_q;

endmodule

// File: tb/tb_pwm_multichannel_gen.sv
// Directed bench for pwm_multichannel_gen with hand-computed period/high-time expectations.
module tb_pwm_multichannel_gen;
  import pwm_pkg::*;

  localparam int unsigned N_CH  = 4;
  localparam int          LIMIT = 5000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_multichannel_gen_if #(.N_CH(N_CH)) bus ();

  pwm_multichannel_gen #(
    .N_CH  (N_CH),
    .PERIOD(100),
    .CW    (7),
    .STEP  (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n, per, hi, oth, edges, acc;
  logic prev;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit up, input int ch, input int cnt);
    repeat (cnt) begin
      if (up) bus.xu[ch] = 1'b1;
      else    bus.xd[ch] = 1'b1;
      step();
      bus.xu[ch] = 1'b0;
      bus.xd[ch] = 1'b0;
      step();
    end
  endtask

  task automatic wait_sync(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (bus.sync !== 1'b1 && cyc < LIMIT);
  endtask

  // Starts on a sync sample, stops on the next one.
  task automatic measure(input int ch, output int period, output int high, output int other);
    logic [N_CH-1:0] sel;
    sel = N_CH'(1) << ch;
    period = 0;
    high   = 0;
    other  = 0;
    do begin
      high  += int'(bus.pwm[ch]);
      other += int'(|(bus.pwm & ~sel));
      period++;
      step();
    end while (bus.sync !== 1'b1 && period < LIMIT);
  endtask

  initial begin
    rst = 1'b1;
    bus.ena = 1'b0; bus.conf = '0; bus.mode = MODE_EDGE;
    bus.xu = '0; bus.xd = '0;
    repeat (2) step();
    check_eq("reset_pwm", int'(bus.pwm), 0);
    check_eq("reset_sync", int'(bus.sync), 0);
    rst = 1'b0;
    bus.ena = 1'b1;

    // Edge mode, duty 25 on ch0
    pulse(1'b1, 0, 25);
    wait_sync(n);
    check_eq("first_sync", int'(bus.sync), 1);
    measure(0, per, hi, oth);
    measure(0, per, hi, oth);
    check_eq("ch0_period", per, 100);
    check_eq("ch0_high", hi, 25);
    check_eq("others_idle", oth, 0);

    // Prescaler /8, duty 50 on ch1
    pulse(1'b1, 1, 50);
    bus.conf = 3'd3;
    wait_sync(n);
    measure(1, per, hi, oth);
    measure(1, per, hi, oth);
    check_eq("conf3_period", per, 800);
    check_eq("conf3_high", hi, 400);
    repeat (200) step();
    bus.conf = 3'd0;
    wait_sync(n);
    check_eq("conf_switch_remain", n, 75);
    measure(1, per, hi, oth);
    check_eq("conf0_period", per, 100);
    check_eq("conf0_high", hi, 50);

    // Saturation
    pulse(1'b1, 2, 105);
    wait_sync(n);
    measure(2, per, hi, oth);
    measure(2, per, hi, oth);
    check_eq("sat_hi_high", hi, 100);
    pulse(1'b0, 2, 3);
    wait_sync(n);
    measure(2, per, hi, oth);
    measure(2, per, hi, oth);
    check_eq("sat_dn3_high", hi, 97);
    pulse(1'b0, 3, 3);
    pulse(1'b1, 3, 1);
    wait_sync(n);
    measure(3, per, hi, oth);
    measure(3, per, hi, oth);
    check_eq("sat_lo_nowrap", hi, 1);

    // Mid-period duty change on ch0 (25 -> 30, then +1 at cnt=10)
    pulse(1'b1, 0, 5);
    wait_sync(n);
    hi = 0; edges = 0; prev = bus.pwm[0];
    for (int k = 0; k < 100; k++) begin
      hi += int'(bus.pwm[0]);
      if (k > 0 && bus.pwm[0] && !prev) edges++;
      prev = bus.pwm[0];
      if (k == 10) bus.xu[0] = 1'b1;
      if (k == 12) bus.xu[0] = 1'b0;
      step();
    end
    check_eq("mid_cur_high", hi, 30);
    check_eq("mid_cur_edges", edges, 1);
    check_eq("mid_sync_at_100", int'(bus.sync), 1);
    measure(0, per, hi, oth);
    check_eq("mid_next_high", hi, 31);

    // Center mode, duty 40 on ch1; mode change waits for the boundary
    pulse(1'b0, 1, 10);
    wait_sync(n);
    repeat (30) step();
    bus.mode = MODE_CENTER;
    wait_sync(n);
    check_eq("mode_switch_remain", n, 70);
    measure(1, per, hi, oth);
    measure(1, per, hi, oth);
    check_eq("center_period", per, 200);
    check_eq("center_high", hi, 80);

    // Simultaneous xu/xd on ch3 (duty 1)
    bus.xu[3] = 1'b1; bus.xd[3] = 1'b1;
    step();
    bus.xu[3] = 1'b0; bus.xd[3] = 1'b0;
    step();
    wait_sync(n);
    measure(3, per, hi, oth);
    check_eq("simul_high", hi, 2);

    // Freeze with ena=0 mid-pulse on ch1; xu edge while disabled is ignored
    repeat (10) step();
    check_eq("pre_freeze_pwm1", int'(bus.pwm[1]), 1);
    bus.ena = 1'b0;
    bus.xu[1] = 1'b1;
    step();
    check_eq("freeze_pwm", int'(bus.pwm), 0);
    acc = 0;
    repeat (49) begin
      acc += int'(|bus.pwm) + int'(bus.sync);
      step();
    end
    check_eq("freeze_quiet", acc, 0);
    bus.ena = 1'b1;
    wait_sync(n);
    check_eq("resume_remain", n, 190);
    bus.xu[1] = 1'b0;
    measure(1, per, hi, oth);
    check_eq("resume_period", per, 200);
    check_eq("resume_high", hi, 80);

    // Synchronous reset mid-pulse
    repeat (5) step();
    check_eq("pre_rst_pwm1", int'(bus.pwm[1]), 1);
    rst = 1'b1;
    step();
    check_eq("rst_pwm", int'(bus.pwm), 0);
    check_eq("rst_sync", int'(bus.sync), 0);
    rst = 1'b0;
    bus.mode = MODE_EDGE;
    acc = 0;
    repeat (300) begin
      acc += int'(|bus.pwm);
      step();
    end
    check_eq("post_rst_duty0", acc, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
